step_scheduler: RTL and testbench
=================================

# step_scheduler

Sequencing controller for the five-digit HEX0 roll-number sequencer. Decides *when* the sequencer advances, from two sources: a synchronised manual step button, and a programmable auto-advance timer. It emits a one-cycle `step` pulse with a direction, plus a `home` pulse. It tracks the sequencer position `pos` modulo `N_STATES`, so the sequencer's state register can be driven from `step`/`home` alone.

## Interface
- `N_STATES`, 5: positions in the sequence; `pos` wraps modulo this.
- `TICK_W`, 24: width of auto-advance period and tick counter.
- `LOCKOUT`, 16: cycles after an accepted press during which further presses on that key are ignored.
- `clk`  in  1  rising-edge clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_step_n`  in  1  manual step button, active-low, asynchronous to `clk`.
- `key_home_n`  in  1  home button, active-low, asynchronous to `clk`.
- `dir_up`  in  1  1 = forward (pos+1), 0 = backward (pos-1); sampled in the cycle a step is issued.
- `auto_en`  in  1  enables auto-advance timer.
- `period`  in  TICK_W  auto-advance interval in cycles; 0 disables auto steps.
- `step`  out  1  one-cycle advance pulse to sequencer.
- `step_dir`  out  1  direction accompanying `step`; holds the last issued value.
- `home`  out  1  one-cycle pulse: sequencer must return to its first state.
- `pos`  out  3  current position, 0..N_STATES-1.
- `lap`  out  1  one-cycle pulse when `pos` wraps (N-1→0 forward, 0→N-1 backward).

## Operation
- **Key front end.** Each key passes through a 2-FF synchroniser, with the flops reset to 1. A falling edge of the synchronised level is a *press*. A press is accepted only if that key's lockout counter is 0. Acceptance loads the counter with `LOCKOUT`; it then decrements to 0.
- **FSM states:** IDLE, RUN, HOME.
- **IDLE.** Tick counter is held at 0.
  - Accepted step press → `step`.
  - `auto_en`=1 and `period`≠0 → RUN.
- **RUN.** Tick counter increments each cycle.
  - At `period`-1: `step`, then counter returns to 0.
  - An accepted step press issues `step` and clears the counter. A timer expiry in the same cycle is absorbed, giving one step, not two.
  - `auto_en`=0 or `period`=0 → IDLE, counter cleared.
  - A `period` change takes effect at the next comparison. If count ≥ new `period`-1, that cycle counts as expiry.
- **HOME.** Entered from any state on an accepted home press.
  - Home has priority over any step in the same cycle; that step is dropped.
  - In HOME: `home`=1 for exactly one cycle, `pos`←0, counter←0, no `step`, no `lap`.
  - Next state is RUN if (`auto_en` && `period`≠0), else IDLE.
- **Position update.** On `step`, `pos`←(`pos`+1) mod N if `dir_up`, else (`pos`+N-1) mod N. `step_dir`←`dir_up`. `lap`=1 in the same cycle as `step` when a wrap occurs.
- **Arithmetic.** The counter is unsigned `TICK_W` bits and never wraps, because it clears at expiry.

## Timing
- **Reset values:** `step`=0, `step_dir`=1, `home`=0, `pos`=0, `lap`=0, state IDLE, counters 0, synchroniser flops 1.
- **Reset mid-operation:** everything returns to reset values immediately. No pulse is emitted on reset release.
- **Manual latency.** The key is first sampled low at rising edge E. `step` (or `home`) is high in the cycle after edge E+2, i.e. 3 cycles.
- **Auto latency.** In RUN with a stable `period`=P, `step` pulses every P cycles. The first pulse occurs P cycles after RUN entry.
- **Output registers.** `step`, `home` and `lap` are registered and never high for two consecutive cycles from the same event. `pos` updates on the same edge that raises `step`.
- **Key glitches.** A key held low produces one press. Bounces inside the `LOCKOUT` window produce none.

## Structure
- **Shared package:** FSM state encoding (IDLE/RUN/HOME), default `N_STATES`, `TICK_W`, `LOCKOUT`. The sequencer and this block share `N_STATES`.
- **Sub-module `key_sync`:** 2-FF synchroniser, falling-edge detect and lockout counter. Instantiated once per key.
- **Top level:** FSM, tick counter, and position counter.

## Test plan
- **Reset:** assert `reset_n`=0 mid-RUN with `pos`=3 → all outputs at reset values next cycle; no `step` after release.
- **Manual forward lap:** `auto_en`=0, `dir_up`=1, five presses spaced > `LOCKOUT` → `pos` 1,2,3,4,0, each 3 cycles after press; `lap` only on 4→0.
- **Backward wrap:** `dir_up`=0 from `pos`=0, one press → `pos`=4, `lap`=1, `step_dir`=0.
- **Auto timing and collision:**
  - `auto_en`=1, `period`=10 → `step` every 10 cycles.
  - Inject a press landing on an expiry cycle → a single `step`, next auto step 10 cycles later.
- **Home priority:** home and step presses land in the same cycle at `pos`=2 → `home`=1, `pos`=0, no `step`; returns to RUN.
- **Bounce and period 0:**
  - Toggle `key_step_n` 4 times within 8 cycles (`LOCKOUT`=16) → exactly one `step`.
  - `period`=0 with `auto_en`=1 → IDLE, no auto steps.

Source files
------------

// File: rtl/step_scheduler_pkg.sv
// Shared definitions for the HEX0 roll-number step scheduler and its sequencer.
// Holds the FSM encoding, default sizing, and the position-advance helper.
// No logic; imported by every file of the block.
package step_scheduler_pkg;

  // Number of positions in the roll-number sequence (shared with the sequencer).
  localparam int SEQ_N_STATES = 5;
  // Width of the auto-advance period and tick counter.
  localparam int SEQ_TICK_W   = 24;
  // Cycles a key stays deaf after an accepted press.
  localparam int SEQ_LOCKOUT  = 16;
  // Width of the position output.
  localparam int POS_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOME = 2'd2
  } state_t;

  // Next position modulo (last+1): forward wraps last->0, backward wraps 0->last.
  function automatic logic [POS_W-1:0] pos_next(
    input logic [POS_W-1:0] p,
    input logic             up,
    input logic [POS_W-1:0] last
  );
    logic [POS_W-1:0] r;
    if (up) begin
      r = (p == last) ? '0 : p + POS_W'(1);
    end else begin
      r = (p == '0) ? last : p - POS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/step_scheduler_key_sync.sv
// Key front end: 2-FF synchroniser, falling-edge press detect, per-key lockout.
// Latency: press is flagged in the cycle after the second sync flop first reads low.
// No backpressure: presses arriving while the lockout counter is non-zero are dropped.
module key_sync
  import step_scheduler_pkg::*;
#(
  parameter int LOCKOUT = SEQ_LOCKOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int LW = $clog2(LOCKOUT + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [LW-1:0] r_lock;
  logic          w_fall;

  // A press is a high-to-low transition of the synchronised level.
  assign w_fall  = r_prev & ~r_sync2;
  assign o_press = w_fall && (r_lock == '0);

  // Synchroniser chain plus one history flop for edge detection; all idle high
  // so that reset release never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Lockout: reload on an accepted press, then count down to zero and hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock <= '0;
    end else if (o_press) begin
      r_lock <= LW'(LOCKOUT);
    end else if (r_lock != '0) begin
      r_lock <= r_lock - LW'(1);
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Step scheduler: turns manual step/home keys and an auto-advance timer into step/home pulses and tracks pos.
// Latency: key press to pulse 3 cycles; auto step every `period` cycles, first one `period` cycles after RUN entry.
// No backpressure: the sequencer must accept every one-cycle pulse; home pre-empts any same-cycle step.
module step_scheduler
  import step_scheduler_pkg::*;
#(
  parameter int N_STATES = SEQ_N_STATES,
  parameter int TICK_W   = SEQ_TICK_W,
  parameter int LOCKOUT  = SEQ_LOCKOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_step_n,
  input  logic              key_home_n,
  input  logic              dir_up,
  input  logic              auto_en,
  input  logic [TICK_W-1:0] period,
  output logic              step,
  output logic              step_dir,
  output logic              home,
  output logic [POS_W-1:0]  pos,
  output logic              lap
);

  localparam logic [POS_W-1:0] LAST = POS_W'(N_STATES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TICK_W-1:0] r_cnt;
  logic [TICK_W-1:0] w_cnt_nxt;
  logic              r_step;
  logic              r_home;
  logic              r_lap;
  logic              r_dir;
  logic [POS_W-1:0]  r_pos;
  logic              w_step_nxt;
  logic              w_home_nxt;
  logic              w_step_press;
  logic              w_home_press;
  logic              w_auto_ok;
  logic              w_expire;
  logic              w_wrap;

  key_sync #(.LOCKOUT(LOCKOUT)) u_key_step (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (key_step_n),
    .o_press (w_step_press)
  );

  key_sync #(.LOCKOUT(LOCKOUT)) u_key_home (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (key_home_n),
    .o_press (w_home_press)
  );

  // Timer is live only with a non-zero period. Comparing with >= makes a
  // period shrunk below the current count expire immediately instead of
  // letting the counter run away.
  assign w_auto_ok = auto_en && (period != '0);
  assign w_expire  = (period != '0) && (r_cnt >= (period - TICK_W'(1)));
  assign w_wrap    = dir_up ? (r_pos == LAST) : (r_pos == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next tick count and next pulse values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    w_home_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_home_press) begin
          w_state_nxt = ST_HOME;
          w_home_nxt  = 1'b1;
        end else begin
          w_step_nxt = w_step_press;
          if (w_auto_ok) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_home_press) begin
          w_state_nxt = ST_HOME;
          w_home_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else if (!w_auto_ok) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_step_nxt  = w_step_press;
        end else if (w_step_press || w_expire) begin
          // Manual press and expiry in the same cycle merge into one step.
          w_step_nxt = 1'b1;
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + TICK_W'(1);
        end
      end
      ST_HOME: begin
        // One-cycle state while home is high; any step here is discarded.
        w_cnt_nxt   = '0;
        w_state_nxt = w_auto_ok ? ST_RUN : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Registered outputs, tick counter and position, all updated on the pulse edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
      r_home <= 1'b0;
      r_lap  <= 1'b0;
      r_dir  <= 1'b1;
      r_pos  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_step <= w_step_nxt;
      r_home <= w_home_nxt;
      r_lap  <= w_step_nxt & w_wrap;
      if (w_home_nxt) begin
        r_pos <= '0;
      end else if (w_step_nxt) begin
        r_pos <= pos_next(r_pos, dir_up, LAST);
        r_dir <= dir_up;
      end
    end
  end

  assign step     = r_step;
  assign home     = r_home;
  assign lap      = r_lap;
  assign step_dir = r_dir;
  assign pos      = r_pos;

endmodule

// File: tb/tb_step_scheduler.sv
module tb_step_scheduler;
  import step_scheduler_pkg::*;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        key_step_n = 1'b1;
  logic        key_home_n = 1'b1;
  logic        dir_up     = 1'b1;
  logic        auto_en    = 1'b0;
  logic [23:0] period     = 24'd0;
  logic        step;
  logic        step_dir;
  logic        home;
  logic [2:0]  pos;
  logic        lap;

  int errors   = 0;
  int checks   = 0;
  int step_cnt = 0;
  int home_cnt = 0;

  typedef struct {
    logic       dir;
    logic [2:0] exp_pos;
    logic       exp_lap;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  step_scheduler #(.N_STATES(5), .TICK_W(24), .LOCKOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_step_n (key_step_n),
    .key_home_n (key_home_n),
    .dir_up     (dir_up),
    .auto_en    (auto_en),
    .period     (period),
    .step       (step),
    .step_dir   (step_dir),
    .home       (home),
    .pos        (pos),
    .lap        (lap)
  );

  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (home === 1'b1) home_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Manual press: key goes low at a negedge; step must appear at the third negedge after.
  task automatic do_press(input logic d, input logic [2:0] ep, input logic el);
    @(negedge clk);
    dir_up     = d;
    key_step_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("man_step_early", 32'(step), 32'd0);
    @(negedge clk);
    chk("man_step", 32'(step), 32'd1);
    chk("man_pos", 32'(pos), 32'(ep));
    chk("man_lap", 32'(lap), 32'(el));
    chk("man_dir", 32'(step_dir), 32'(d));
    @(negedge clk);
    chk("man_step_once", 32'(step), 32'd0);
    chk("man_lap_once", 32'(lap), 32'd0);
    @(negedge clk);
    key_step_n = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    int  base;
    logic exp_step;

    vecs[0] = '{1'b1, 3'd1, 1'b0};
    vecs[1] = '{1'b1, 3'd2, 1'b0};
    vecs[2] = '{1'b1, 3'd3, 1'b0};
    vecs[3] = '{1'b1, 3'd4, 1'b0};
    vecs[4] = '{1'b1, 3'd0, 1'b1};
    vecs[5] = '{1'b0, 3'd4, 1'b1};
    vecs[6] = '{1'b0, 3'd3, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_step_dir", 32'(step_dir), 32'd1);
    chk("rst_home", 32'(home), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_lap", 32'(lap), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_pulse_on_release", 32'(step_cnt + home_cnt), 32'd0);

    // Manual forward lap then backward wrap
    for (int v = 0; v < 7; v++) begin
      do_press(vecs[v].dir, vecs[v].exp_pos, vecs[v].exp_lap);
    end

    // Auto timing, home priority, press/expiry collision (pos starts at 3)
    @(negedge clk);
    dir_up  = 1'b1;
    period  = 24'd10;
    auto_en = 1'b1;
    for (int i = 1; i <= 85; i++) begin
      @(negedge clk);
      exp_step = (i == 11) || (i == 21) || (i == 31) || (i == 41) ||
                 (i == 58) || (i == 68) || (i == 78);
      chk($sformatf("auto_step_c%0d", i), 32'(step), 32'(exp_step));
      chk($sformatf("auto_lap_c%0d", i), 32'(lap), 32'(i == 21));
      case (i)
        11: chk("auto_pos_11", 32'(pos), 32'd4);
        21: chk("auto_pos_21", 32'(pos), 32'd0);
        41: chk("auto_pos_41", 32'(pos), 32'd2);
        47: begin
          chk("home_pulse", 32'(home), 32'd1);
          chk("home_pos", 32'(pos), 32'd0);
        end
        48: chk("home_once", 32'(home), 32'd0);
        58: chk("run_after_home_pos", 32'(pos), 32'd1);
        68: chk("collide_pos", 32'(pos), 32'd2);
        78: chk("after_collide_pos", 32'(pos), 32'd3);
        default: ;
      endcase
      if (i == 44) begin
        key_step_n = 1'b0;
        key_home_n = 1'b0;
      end
      if (i == 50) begin
        key_step_n = 1'b1;
        key_home_n = 1'b1;
      end
      if (i == 65) key_step_n = 1'b0;
      if (i == 70) key_step_n = 1'b1;
    end
    chk("home_count", 32'(home_cnt), 32'd1);

    // Reset mid-RUN at pos 3
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_step", 32'(step), 32'd0);
    chk("mid_rst_step_dir", 32'(step_dir), 32'd1);
    chk("mid_rst_home", 32'(home), 32'd0);
    chk("mid_rst_pos", 32'(pos), 32'd0);
    chk("mid_rst_lap", 32'(lap), 32'd0);
    reset_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk($sformatf("post_rst_step_c%0d", j), 32'(step), 32'(j == 11));
    end
    chk("post_rst_pos", 32'(pos), 32'd1);
    auto_en = 1'b0;

    // Bounce: four toggles inside the lockout window give one step
    repeat (3) @(negedge clk);
    base = step_cnt;
    key_step_n = 1'b0;
    repeat (2) @(negedge clk);
    key_step_n = 1'b1;
    repeat (2) @(negedge clk);
    key_step_n = 1'b0;
    repeat (2) @(negedge clk);
    key_step_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("bounce_steps", 32'(step_cnt - base), 32'd1);
    chk("bounce_pos", 32'(pos), 32'd2);

    // Period 0 with auto enabled: no auto steps
    period  = 24'd0;
    auto_en = 1'b1;
    base    = step_cnt;
    repeat (40) @(negedge clk);
    chk("period0_steps", 32'(step_cnt - base), 32'd0);
    chk("period0_pos", 32'(pos), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
